i2c_slave_mem: RTL and testbench



---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_bus_sync.sv | 46 ++++
 rtl/i2c_slave_mem.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C EEPROM-style responder.
package i2c_pkg;

    // Transaction phases of the responder.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEV     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_WR      = 3'd4,
        ST_RD      = 3'd5
    } state_e;

    localparam logic [6:0] SLAVE_ADDR_DEF = 7'h50;

    // Bit counter positions within a byte (MSB travels first).
    localparam logic [2:0] BIT_FIRST = 3'd0;
    localparam logic [2:0] BIT_LAST  = 3'd7;

    // Level of SDA during the acknowledge slot.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Next memory pointer: 16-bit mode wraps FFFF->0000, 8-bit mode wraps
    // the low byte only and keeps the high byte at zero.
    function automatic logic [15:0] ptr_inc(input logic [15:0] ptr, input logic wide);
        logic [15:0] nxt;
        if (wide) begin
            nxt = ptr + 16'd1;
        end else begin
            nxt = {8'h00, ptr[7:0] + 8'd1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA into the clk domain and decodes edges and START/STOP.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    // Idle bus is high, so every stage resets to 1 to avoid a fake edge.
    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;

    // Two-stage synchroniser followed by one history stage per line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_in;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
        end
    end

    assign sda_s    = sda_sync_q;
    assign scl_rise = scl_sync_q & ~scl_hist_q;
    assign scl_fall = ~scl_sync_q & scl_hist_q;

    // SDA may only move while SCL is low; a move during stable-high SCL is a
    // bus condition rather than data.
    assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C responder emulating an EEPROM: device address, 8/16-bit word address,
// sequential writes and reads through a synchronous memory port.
// SDA is open-drain: sda_oe=1 pulls the line low, 0 releases it.
module i2c_slave_mem
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF,
    parameter int         SYS_CLK    = 50_000_000,
    parameter int         MAX_SCL    = 250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_ctrl,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output state_e      dbg_state_o
);

    // The bus decoder needs at least 16 clk per SCL period to see each phase.
    if (SYS_CLK / MAX_SCL < 16) begin : g_ratio_check
        $error("i2c_slave_mem: SYS_CLK/MAX_SCL must be at least 16");
    end

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;     // data bits seen in the current byte
    logic        ack_phase_q, ack_phase_d; // next SCL rise is the 9th (ack) bit
    logic [7:0]  shift_q, shift_d;
    logic [15:0] ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        wide_q, wide_d;           // bit_ctrl captured at START
    logic [7:0]  rx_byte;

    // State and datapath registers; reset releases SDA at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= BIT_FIRST;
            ack_phase_q <= 1'b0;
            shift_q     <= 8'h00;
            ptr_q       <= 16'h0000;
            sda_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
            wide_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_phase_q <= ack_phase_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            wide_q      <= wide_d;
        end
    end

    // Next-state logic: bus conditions first, then per-state SCL edge handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ack_phase_d = ack_phase_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        wide_d      = wide_q;
        rx_byte     = {shift_q[6:0], sda_s};

        // The pointer advances the clk after the write strobe is presented.
        if (mem_we_q) begin
            ptr_d = ptr_inc(ptr_q, wide_q);
        end

        if (stop_det) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = BIT_FIRST;
            ack_phase_d = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps the pointer: that is how random reads work.
            state_d     = ST_DEV;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = BIT_FIRST;
            ack_phase_d = 1'b0;
            wide_d      = bit_ctrl;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_RD: begin
                    if (scl_rise) begin
                        if (ack_phase_q) begin
                            ack_phase_d = 1'b0;
                            if (sda_s == ACK) begin
                                ptr_d = ptr_inc(ptr_q, wide_q);
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == BIT_LAST) begin
                                ack_phase_d = 1'b1;
                            end
                        end
                    end else if (scl_fall) begin
                        if (ack_phase_q) begin
                            // Master owns SDA for its ack.
                            sda_oe_d = 1'b0;
                        end else if (bit_cnt_q == BIT_FIRST) begin
                            // Fall ending the ack slot: fetch and present MSB.
                            shift_d  = mem_rdata;
                            sda_oe_d = ~mem_rdata[7];
                        end else begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[6:0], 1'b0};
                        end
                    end
                end

                default: begin
                    // Receiving states: DEV, ADDR_HI, ADDR_LO, WR.
                    if (scl_rise) begin
                        if (ack_phase_q) begin
                            ack_phase_d = 1'b0;
                            case (state_q)
                                ST_DEV:     state_d = shift_q[0] ? ST_RD
                                                    : (wide_q ? ST_ADDR_HI : ST_ADDR_LO);
                                ST_ADDR_HI: state_d = ST_ADDR_LO;
                                ST_ADDR_LO: state_d = ST_WR;
                                default:    state_d = state_q;
                            endcase
                        end else begin
                            shift_d   = rx_byte;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == BIT_LAST) begin
                                ack_phase_d = 1'b1;
                                case (state_q)
                                    ST_DEV: begin
                                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                                            busy_d = 1'b1;
                                        end else begin
                                            state_d     = ST_IDLE;
                                            busy_d      = 1'b0;
                                            ack_phase_d = 1'b0;
                                        end
                                    end
                                    ST_ADDR_HI: ptr_d = {rx_byte, ptr_q[7:0]};
                                    ST_ADDR_LO: ptr_d = {(wide_q ? ptr_q[15:8] : 8'h00), rx_byte};
                                    ST_WR: begin
                                        mem_we_d    = 1'b1;
                                        mem_wdata_d = rx_byte;
                                    end
                                    default: begin
                                    end
                                endcase
                            end
                        end
                    end else if (scl_fall) begin
                        // Pull low exactly for the ack slot, release otherwise.
                        sda_oe_d = ack_phase_q;
                    end
                end
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign mem_addr    = ptr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bus master driver at 250 kHz SCL on a 50 MHz clk,
// memory stub, write scoreboard and a transaction-level reference model.
module tb_i2c_slave_mem;
    import i2c_pkg::*;

    localparam int HALF = 100; // clk cycles per SCL half period

    // ---------------- clock / reset / bus ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_ctrl;
    logic        scl_m, sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    state_e      dbg_state;

    always #10 clk = ~clk;

    // Open-drain wired-AND of master and responder.
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_ctrl    (bit_ctrl),
        .scl_in      (scl_m),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- memory stub ----------------
    logic [7:0]  dev_mem [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0;
    logic [7:0]  poke_data = 8'h0;

    always @(posedge clk) begin
        if (poke_en) dev_mem[poke_addr] <= poke_data;
        else if (mem_we) dev_mem[mem_addr] <= mem_wdata;
        mem_rdata <= dev_mem[mem_addr];
    end

    // ---------------- scoreboard ----------------
    logic [23:0] got_q[$];   // {addr, data} of every observed write strobe
    logic [23:0] exp_q[$];   // expected writes from the model
    int          got_rd = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_mem [0:65535];
    logic [15:0] m_ptr = 16'h0;

    function automatic logic [15:0] m_next(input logic [15:0] p, input logic w16);
        logic [15:0] n;
        n = w16 ? 16'((32'(p) + 1) % 65536) : 16'((32'(p[7:0]) + 1) % 256);
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // One SCL clock: SDA set 1 clk after SCL fell, sampled mid-high.
    task automatic clk_bit(input logic b, output logic r);
        @(negedge clk); sda_m = b;
        repeat (HALF - 1) @(negedge clk); scl_m = 1'b1;
        repeat (HALF / 2) @(negedge clk); r = sda_line;
        repeat (HALF / 2) @(negedge clk); scl_m = 1'b0;
    endtask

    task automatic send_start();
        @(negedge clk); sda_m = 1'b1;
        repeat (HALF / 2) @(negedge clk); scl_m = 1'b1;
        repeat (HALF / 2) @(negedge clk); sda_m = 1'b0;
        repeat (HALF / 2) @(negedge clk); scl_m = 1'b0;
    endtask

    task automatic send_stop();
        @(negedge clk); sda_m = 1'b0;
        repeat (HALF / 2) @(negedge clk); scl_m = 1'b1;
        repeat (HALF / 2) @(negedge clk); sda_m = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            b[i] = r;
        end
        clk_bit(m_ack, r);
    endtask

    // Write transaction; counts responder NACKs, reports busy before STOP.
    task automatic wr_txn(input logic w16, input logic [15:0] a, input logic [7:0] d [4],
                          input int n, output int nacks, output logic busy_pre);
        logic ack;
        nacks = 0;
        bit_ctrl = w16;
        send_start();
        write_byte({SLAVE_ADDR_DEF, 1'b0}, ack); nacks += int'(ack);
        if (w16) begin write_byte(a[15:8], ack); nacks += int'(ack); end
        write_byte(a[7:0], ack); nacks += int'(ack);
        for (int i = 0; i < n; i++) begin
            write_byte(d[i], ack); nacks += int'(ack);
        end
        busy_pre = busy;
        send_stop();
    endtask

    // Random read: set address, repeated START, n reads (last one NACKed).
    task automatic rd_txn(input logic w16, input logic [15:0] a, input int n,
                          output logic [7:0] d [4], output int nacks, output logic busy_end);
        logic ack;
        nacks = 0;
        bit_ctrl = w16;
        send_start();
        write_byte({SLAVE_ADDR_DEF, 1'b0}, ack); nacks += int'(ack);
        if (w16) begin write_byte(a[15:8], ack); nacks += int'(ack); end
        write_byte(a[7:0], ack); nacks += int'(ack);
        send_start();
        write_byte({SLAVE_ADDR_DEF, 1'b1}, ack); nacks += int'(ack);
        for (int i = 0; i < n; i++) read_byte((i == n - 1) ? NACK : ACK, d[i]);
        busy_end = busy;
        send_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit_ctrl = 1'b0; scl_m = 1'b1; sda_m = 1'b1; rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (mem_addr !== 16'h0) begin n_errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h0) begin n_errors++; $display("FAIL reset_mem_wdata: got %h expected 00", mem_wdata); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        m_ptr = 16'h0;
    endtask

    task automatic test_write16();
        logic [7:0] d [4];
        int nacks, n_new;
        logic bpre;
        logic [23:0] e, act;
        d[0] = 8'h5A; d[1] = 8'hC3; d[2] = 8'h00; d[3] = 8'h00;
        wr_txn(1'b1, 16'h1234, d, 2, nacks, bpre);
        m_ptr = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({m_ptr, d[i]}); m_mem[m_ptr] = d[i]; m_ptr = m_next(m_ptr, 1'b1);
        end
        n_checks++; if (nacks !== 0) begin n_errors++; $display("FAIL w16_acks: got %0d nacks expected 0", nacks); end
        n_checks++; if (bpre !== 1'b1) begin n_errors++; $display("FAIL w16_busy_pre: got %b expected 1", bpre); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL w16_busy_post: got %b expected 0", busy); end
        n_checks++; if (mem_addr !== m_ptr) begin n_errors++; $display("FAIL w16_ptr: got %h expected %h", mem_addr, m_ptr); end
        n_new = got_q.size() - got_rd;
        n_checks++; if (n_new !== exp_q.size()) begin n_errors++; $display("FAIL w16_wr_count: got %0d expected %0d", n_new, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = (got_rd < got_q.size()) ? got_q[got_rd] : 24'hFFFFFF;
            n_checks++; if (act !== e) begin n_errors++; $display("FAIL w16_wr: got %h expected %h", act, e); end
            got_rd++;
        end
        got_rd = got_q.size();
    endtask

    task automatic test_random_read8();
        logic [7:0] d [4];
        int nacks;
        logic bend;
        logic [7:0] e;
        poke(16'h0010, 8'h77); m_mem[16'h0010] = 8'h77;
        poke(16'h0011, 8'h88); m_mem[16'h0011] = 8'h88;
        rd_txn(1'b0, 16'h0010, 2, d, nacks, bend);
        m_ptr = 16'h0010;
        n_checks++; if (nacks !== 0) begin n_errors++; $display("FAIL rd8_acks: got %0d nacks expected 0", nacks); end
        for (int i = 0; i < 2; i++) begin
            e = m_mem[m_ptr];
            n_checks++; if (d[i] !== e) begin n_errors++; $display("FAIL rd8_data%0d: got %h expected %h", i, d[i], e); end
            if (i < 1) m_ptr = m_next(m_ptr, 1'b0);
        end
        n_checks++; if (bend !== 1'b0) begin n_errors++; $display("FAIL rd8_busy_nack: got %b expected 0", bend); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL rd8_state: got %0d expected IDLE", dbg_state); end
        n_checks++; if (mem_addr !== m_ptr) begin n_errors++; $display("FAIL rd8_ptr: got %h expected %h", mem_addr, m_ptr); end
        n_checks++; if (got_q.size() != got_rd) begin n_errors++; $display("FAIL rd8_no_write: got %0d writes expected 0", got_q.size() - got_rd); end
        got_rd = got_q.size();
    endtask

    task automatic test_mismatch();
        logic ack;
        bit_ctrl = 1'b0;
        send_start();
        write_byte({7'h51, 1'b0}, ack);
        n_checks++; if (ack !== NACK) begin n_errors++; $display("FAIL mis_ack: got %b expected 1", ack); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mis_busy: got %b expected 0", busy); end
        write_byte(8'h3C, ack);
        n_checks++; if (ack !== NACK) begin n_errors++; $display("FAIL mis_data_ack: got %b expected 1", ack); end
        send_stop();
        n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL mis_state: got %0d expected IDLE", dbg_state); end
        n_checks++; if (got_q.size() != got_rd) begin n_errors++; $display("FAIL mis_no_write: got %0d writes expected 0", got_q.size() - got_rd); end
        got_rd = got_q.size();
    endtask

    task automatic test_wrap();
        logic [7:0] d [4];
        int nacks, n_new;
        logic bpre;
        logic [23:0] e, act;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
            wr_txn(k[0], 16'hFFFF, d, 2, nacks, bpre);
            m_ptr = k[0] ? 16'hFFFF : 16'h00FF;
            for (int i = 0; i < 2; i++) begin
                exp_q.push_back({m_ptr, d[i]}); m_mem[m_ptr] = d[i]; m_ptr = m_next(m_ptr, k[0]);
            end
            n_checks++; if (nacks !== 0) begin n_errors++; $display("FAIL wrap%0d_acks: got %0d nacks expected 0", k, nacks); end
            n_checks++; if (mem_addr !== m_ptr) begin n_errors++; $display("FAIL wrap%0d_ptr: got %h expected %h", k, mem_addr, m_ptr); end
        end
        n_new = got_q.size() - got_rd;
        n_checks++; if (n_new !== exp_q.size()) begin n_errors++; $display("FAIL wrap_wr_count: got %0d expected %0d", n_new, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = (got_rd < got_q.size()) ? got_q[got_rd] : 24'hFFFFFF;
            n_checks++; if (act !== e) begin n_errors++; $display("FAIL wrap_wr: got %h expected %h", act, e); end
            got_rd++;
        end
        got_rd = got_q.size();
    endtask

    task automatic test_abort();
        logic ack, r;
        int nacks;
        bit_ctrl = 1'b1;
        nacks = 0;
        send_start();
        write_byte(8'hA0, ack); nacks += int'(ack);
        write_byte(8'h00, ack); nacks += int'(ack);
        write_byte(8'h40, ack); nacks += int'(ack);
        for (int i = 0; i < 4; i++) clk_bit(i[0], r);
        send_stop();
        m_ptr = 16'h0040;
        n_checks++; if (nacks !== 0) begin n_errors++; $display("FAIL abort_acks: got %0d nacks expected 0", nacks); end
        n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL abort_sda_oe: got %b expected 0", sda_oe); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL abort_state: got %0d expected IDLE", dbg_state); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (got_q.size() != got_rd) begin n_errors++; $display("FAIL abort_no_write: got %0d writes expected 0", got_q.size() - got_rd); end
        got_rd = got_q.size();

        // Reset while the responder is pulling SDA low for a 0 data bit.
        poke(16'h0040, 8'h3C); m_mem[16'h0040] = 8'h3C;
        send_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        write_byte(8'h40, ack);
        send_start();
        write_byte(8'hA1, ack);
        repeat (10) @(negedge clk);
        n_checks++; if (sda_oe !== ~m_mem[m_ptr][7]) begin n_errors++; $display("FAIL rd_bit7_drive: got %b expected %b", sda_oe, ~m_mem[m_ptr][7]); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL rst_release_sda: got %b expected 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        scl_m = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 16'h0;
        repeat (10) @(negedge clk);
        n_checks++; if (mem_addr !== m_ptr) begin n_errors++; $display("FAIL rst_ptr: got %h expected %h", mem_addr, m_ptr); end
    endtask

    task automatic test_random();
        logic [7:0] d [4];
        logic [7:0] q [4];
        logic [15:0] a;
        logic w16, bflag;
        int nacks, n_new;
        logic [23:0] e, act;
        w16 = 1'($urandom_range(0, 1));
        a = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
        wr_txn(w16, a, d, 2, nacks, bflag);
        m_ptr = w16 ? a : {8'h00, a[7:0]};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({m_ptr, d[i]}); m_mem[m_ptr] = d[i]; m_ptr = m_next(m_ptr, w16);
        end
        n_checks++; if (nacks !== 0) begin n_errors++; $display("FAIL rnd_wr_acks: got %0d nacks expected 0", nacks); end
        n_new = got_q.size() - got_rd;
        n_checks++; if (n_new !== exp_q.size()) begin n_errors++; $display("FAIL rnd_wr_count: got %0d expected %0d", n_new, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = (got_rd < got_q.size()) ? got_q[got_rd] : 24'hFFFFFF;
            n_checks++; if (act !== e) begin n_errors++; $display("FAIL rnd_wr: got %h expected %h", act, e); end
            got_rd++;
        end
        got_rd = got_q.size();

        rd_txn(w16, a, 2, q, nacks, bflag);
        m_ptr = w16 ? a : {8'h00, a[7:0]};
        n_checks++; if (nacks !== 0) begin n_errors++; $display("FAIL rnd_rd_acks: got %0d nacks expected 0", nacks); end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (q[i] !== m_mem[m_ptr]) begin n_errors++; $display("FAIL rnd_rd%0d: got %h expected %h", i, q[i], m_mem[m_ptr]); end
            if (i < 1) m_ptr = m_next(m_ptr, w16);
        end
        n_checks++; if (mem_addr !== m_ptr) begin n_errors++; $display("FAIL rnd_ptr: got %h expected %h", mem_addr, m_ptr); end
        n_checks++; if (got_q.size() != got_rd) begin n_errors++; $display("FAIL rnd_rd_no_write: got %0d writes expected 0", got_q.size() - got_rd); end
        got_rd = got_q.size();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write16();
        test_random_read8();
        test_mismatch();
        test_wrap();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #8_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
